// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WDATA = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic OWNER_IC = 1'b0;
    localparam logic OWNER_DC = 1'b1;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    // Beat counter width: clog2 of the larger beat count, never below 1 bit.
    function automatic int unsigned cnt_width(input int unsigned beats,
                                              input int unsigned wbeats);
        int unsigned m;
        int unsigned w;
        m = (beats > wbeats) ? beats : wbeats;
        w = $clog2(m);
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two caches, the memory port and the arbiter.
// slave: arbiter side; master: cache/memory environment side.
interface mem_arbiter_if #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
);
    logic              ic_req_valid;
    logic              ic_req_ready;
    logic [ADDR_W-1:0] ic_req_addr;
    logic              ic_resp_valid;
    logic [DATA_W-1:0] ic_resp_data;

    logic              dc_req_valid;
    logic              dc_req_ready;
    logic              dc_req_rw;
    logic [ADDR_W-1:0] dc_req_addr;
    logic              dc_wdata_valid;
    logic              dc_wdata_ready;
    logic [DATA_W-1:0] dc_wdata;
    logic              dc_resp_valid;
    logic [DATA_W-1:0] dc_resp_data;

    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_req_rw;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_wdata_valid;
    logic              mem_wdata_ready;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_resp_valid;
    logic [DATA_W-1:0] mem_resp_data;

    logic              busy;

    modport slave (
        input  ic_req_valid, ic_req_addr,
        output ic_req_ready, ic_resp_valid, ic_resp_data,
        input  dc_req_valid, dc_req_rw, dc_req_addr, dc_wdata_valid, dc_wdata,
        output dc_req_ready, dc_wdata_ready, dc_resp_valid, dc_resp_data,
        output mem_req_valid, mem_req_rw, mem_req_addr, mem_wdata_valid, mem_wdata,
        input  mem_req_ready, mem_wdata_ready, mem_resp_valid, mem_resp_data,
        output busy
    );

    modport master (
        output ic_req_valid, ic_req_addr,
        input  ic_req_ready, ic_resp_valid, ic_resp_data,
        output dc_req_valid, dc_req_rw, dc_req_addr, dc_wdata_valid, dc_wdata,
        input  dc_req_ready, dc_wdata_ready, dc_resp_valid, dc_resp_data,
        input  mem_req_valid, mem_req_rw, mem_req_addr, mem_wdata_valid, mem_wdata,
        output mem_req_ready, mem_wdata_ready, mem_resp_valid, mem_resp_data,
        input  busy
    );

endinterface

// File: rtl/mem_arbiter_grant.sv
// Grant selection between icache and dcache requesters.
// MEM_ARB_RR_EN: round-robin on contention via a last_served bit;
// otherwise fixed dcache priority.
module arb_grant
    import mem_arb_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic i_ic_valid,
    input  logic i_dc_valid,
    input  logic i_accept,
    output logic o_grant_ic,
    output logic o_grant_dc
);

`ifdef MEM_ARB_RR_EN
    logic r_last_served;

    // Remember who won the most recent accepted grant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_served <= OWNER_IC;
        end else if (i_accept) begin
            r_last_served <= o_grant_dc ? OWNER_DC : OWNER_IC;
        end
    end

    // On contention favour whoever was not served last; a lone requester always wins.
    always_comb begin
        o_grant_dc = i_dc_valid && (!i_ic_valid || (r_last_served == OWNER_IC));
        o_grant_ic = i_ic_valid && !o_grant_dc;
    end
`else
    logic w_unused;
    assign w_unused = clk ^ reset ^ i_accept;

    // dcache holds the older instruction, so it wins whenever it asks.
    always_comb begin
        o_grant_dc = i_dc_valid;
        o_grant_ic = i_ic_valid && !i_dc_valid;
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Serialises icache refills and dcache refills/writebacks onto one memory port.
// Optional MEM_ARB_RR_EN selects round-robin arbitration in arb_grant.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128,
    parameter int BEATS  = 4,
    parameter int WBEATS = 4
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);

    localparam int unsigned CNT_W = cnt_width(BEATS, WBEATS);

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_owner;
    logic              r_rw;
    logic [ADDR_W-1:0] r_addr;

    logic w_grant_ic;
    logic w_grant_dc;
    logic w_ic_hs;
    logic w_dc_hs;
    logic w_idle;
    logic w_wbeat;
    logic w_rbeat;

    assign w_idle  = (r_state == IDLE);
    // Ready is gated by reset so nothing is offered while reset is held.
    assign w_ic_hs = w_idle && !reset && w_grant_ic;
    assign w_dc_hs = w_idle && !reset && w_grant_dc;
    assign w_wbeat = (r_state == WDATA) && bus.dc_wdata_valid && bus.mem_wdata_ready;
    assign w_rbeat = (r_state == RESP) && bus.mem_resp_valid;

    arb_grant u_grant (
        .clk        (clk),
        .reset      (reset),
        .i_ic_valid (bus.ic_req_valid),
        .i_dc_valid (bus.dc_req_valid),
        .i_accept   (w_ic_hs || w_dc_hs),
        .o_grant_ic (w_grant_ic),
        .o_grant_dc (w_grant_dc)
    );

    // Transaction FSM: latch the granted request, then drive beats until the last one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_owner <= OWNER_DC;
            r_rw    <= RW_READ;
            r_addr  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_dc_hs) begin
                        r_owner <= OWNER_DC;
                        r_rw    <= bus.dc_req_rw;
                        r_addr  <= bus.dc_req_addr;
                        r_state <= REQ;
                    end else if (w_ic_hs) begin
                        r_owner <= OWNER_IC;
                        r_rw    <= RW_READ;
                        r_addr  <= bus.ic_req_addr;
                        r_state <= REQ;
                    end
                end
                REQ: begin
                    if (bus.mem_req_ready) begin
                        r_cnt   <= '0;
                        r_state <= (r_rw == RW_WRITE) ? WDATA : RESP;
                    end
                end
                WDATA: begin
                    if (w_wbeat) begin
                        if (r_cnt == CNT_W'(WBEATS - 1)) begin
                            r_cnt   <= '0;
                            r_state <= IDLE;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                RESP: begin
                    if (w_rbeat) begin
                        if (r_cnt == CNT_W'(BEATS - 1)) begin
                            r_cnt   <= '0;
                            r_state <= IDLE;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.ic_req_ready    = w_ic_hs;
    assign bus.dc_req_ready    = w_dc_hs;

    assign bus.mem_req_valid   = (r_state == REQ);
    assign bus.mem_req_rw      = r_rw;
    assign bus.mem_req_addr    = r_addr;

    assign bus.mem_wdata_valid = (r_state == WDATA) && bus.dc_wdata_valid;
    assign bus.dc_wdata_ready  = (r_state == WDATA) && bus.mem_wdata_ready;
    assign bus.mem_wdata       = bus.dc_wdata;

    assign bus.ic_resp_valid   = w_rbeat && (r_owner == OWNER_IC);
    assign bus.dc_resp_valid   = w_rbeat && (r_owner == OWNER_DC);
    assign bus.ic_resp_data    = bus.mem_resp_data;
    assign bus.dc_resp_data    = bus.mem_resp_data;

    assign bus.busy            = !w_idle;

endmodule
